// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stall, flush, forwarding, mult/div tracking.
// Define HAZ_FORWARDING_EN to enable EX-stage forwarding; otherwise dependent instructions stall.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_md,
  input  logic              id_reads_hilo,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MDW = (MD_LAT < 2) ? 1 : $clog2(MD_LAT + 1);

  typedef enum logic {RUN, MD_WAIT} md_state_e;

  md_state_e        state_q, state_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       raw_stall, md_stall, stall, md_issue;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // $zero is hardwired, so a producer targeting r0 never creates a dependency.
  function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] src);
    return we && (rd == src) && (rd != '0);
  endfunction

`ifdef HAZ_FORWARDING_EN
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (hit(mem_reg_write, mem_rd, ex_rs))     fwd_a_raw = 2'b10;
    else if (hit(wb_reg_write, wb_rd, ex_rs))  fwd_a_raw = 2'b01;
    if (hit(mem_reg_write, mem_rd, ex_rt))     fwd_b_raw = 2'b10;
    else if (hit(wb_reg_write, wb_rd, ex_rt))  fwd_b_raw = 2'b01;
    raw_stall = ex_mem_read &&
                ((id_uses_rs && hit(ex_reg_write, ex_rd, id_rs)) ||
                 (id_uses_rt && hit(ex_reg_write, ex_rd, id_rt)));
  end
`else
  // WB is never a hazard here: the regfile writes before it is read in the same cycle.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_reg_write, ex_mem_read};

  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    raw_stall = (id_uses_rs && (hit(ex_reg_write, ex_rd, id_rs) ||
                                hit(mem_reg_write, mem_rd, id_rs))) ||
                (id_uses_rt && (hit(ex_reg_write, ex_rd, id_rt) ||
                                hit(mem_reg_write, mem_rd, id_rt)));
  end
`endif

  assign md_busy  = (state_q == MD_WAIT);
  assign md_stall = md_busy && (id_is_md || id_reads_hilo);
  assign stall    = raw_stall || md_stall;
  assign md_issue = id_is_md && !stall && !ex_branch_taken;

  // A taken branch squashes the stalled ID instruction, so it wins over any stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (md_issue) begin
          state_d  = MD_WAIT;
          md_cnt_d = MDW'(MD_LAT);
        end
      end
      MD_WAIT: begin
        md_cnt_d = md_cnt_q - MDW'(1);
        if (md_cnt_q == MDW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard testbench for pipe_hazard_ctrl; expectations follow HAZ_FORWARDING_EN if defined.
module tb_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 8;
  localparam int CW  = 4;

`ifdef HAZ_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_STALL = 4'b0001;
  localparam logic [3:0] CTL_BR    = 4'b1111;
  localparam logic [3:0] CTL_RST   = 4'b0011;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] id_rs, id_rt;
    logic          id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_branch_taken;
    logic [AW-1:0] mem_rd;
    logic          mem_reg_write;
    logic [AW-1:0] wb_rd;
    logic          wb_reg_write;
  } stim_t;

  typedef struct packed {
    logic [3:0]    ctl;
    logic [1:0]    fa, fb;
    logic          busy;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo;
  logic          ex_reg_write, ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.REG_AW(AW), .MD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  exp_t          exp_q[$];
  string         name_q[$];
  logic [CW-1:0] model_cnt = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic drive(input stim_t s);
    rst = s.rst;
    id_rs = s.id_rs; id_rt = s.id_rt;
    id_uses_rs = s.id_uses_rs; id_uses_rt = s.id_uses_rt;
    id_is_md = s.id_is_md; id_reads_hilo = s.id_reads_hilo;
    ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_rd = s.ex_rd;
    ex_reg_write = s.ex_reg_write; ex_mem_read = s.ex_mem_read;
    ex_branch_taken = s.ex_branch_taken;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_reg_write;
    wb_rd = s.wb_rd; wb_reg_write = s.wb_reg_write;
  endtask

  // One vector per cycle; stall_cnt expectation comes from a saturating counter model.
  task automatic applyStimulus(input string name, input stim_t s, input logic [3:0] ctl,
                               input logic [1:0] fa, input logic [1:0] fb, input logic busy);
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    e.ctl = ctl; e.fa = fa; e.fb = fb; e.busy = busy; e.cnt = model_cnt;
    exp_q.push_back(e);
    name_q.push_back(name);
    if (s.rst) model_cnt = '0;
    else if (!ctl[3] && model_cnt != '1) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput({n, ".ctl"},  16'({pc_write, ifid_write, ifid_flush, idex_bubble}), 16'(e.ctl));
      checkOutput({n, ".fwda"}, 16'(fwd_a), 16'(e.fa));
      checkOutput({n, ".fwdb"}, 16'(fwd_b), 16'(e.fb));
      checkOutput({n, ".busy"}, 16'(md_busy), 16'(e.busy));
      checkOutput({n, ".cnt"},  16'(stall_cnt), 16'(e.cnt));
    end
  end

  initial begin
    stim_t       s, lu, idle;
    logic [63:0] r;
    idle = '0;
    idle.rst = 1'b1;
    drive(idle);
    idle.rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      r = {$urandom(), $urandom()};
      s = stim_t'(r[$bits(stim_t)-1:0]);
      s.rst = 1'b1;
      applyStimulus("reset", s, CTL_RST, 2'b00, 2'b00, 1'b0);
    end
    applyStimulus("release", idle, CTL_RUN, 2'b00, 2'b00, 1'b0);

    lu = idle;
    lu.ex_rd = 5'd3; lu.ex_reg_write = 1'b1; lu.ex_mem_read = 1'b1;
    lu.id_rs = 5'd3; lu.id_uses_rs = 1'b1;
    applyStimulus("lu_ex", lu, CTL_STALL, 2'b00, 2'b00, 1'b0);
    s = idle; s.mem_rd = 5'd3; s.mem_reg_write = 1'b1; s.id_rs = 5'd3; s.id_uses_rs = 1'b1;
    applyStimulus("lu_mem", s, FWD ? CTL_RUN : CTL_STALL, 2'b00, 2'b00, 1'b0);
    s = idle; s.wb_rd = 5'd3; s.wb_reg_write = 1'b1; s.ex_rs = 5'd3;
    s.id_rs = 5'd3; s.id_uses_rs = 1'b1;
    applyStimulus("lu_wb", s, CTL_RUN, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0);

    s = idle; s.ex_rd = 5'd8; s.ex_reg_write = 1'b1; s.id_rs = 5'd8; s.id_uses_rs = 1'b1;
    applyStimulus("alu_dep", s, FWD ? CTL_RUN : CTL_STALL, 2'b00, 2'b00, 1'b0);

    s = idle; s.ex_rs = 5'd5; s.mem_rd = 5'd5; s.mem_reg_write = 1'b1;
    s.wb_rd = 5'd5; s.wb_reg_write = 1'b1;
    applyStimulus("fwd_pri", s, CTL_RUN, FWD ? 2'b10 : 2'b00, 2'b00, 1'b0);
    s = idle; s.ex_rs = 5'd4; s.ex_rt = 5'd9; s.mem_rd = 5'd4; s.mem_reg_write = 1'b1;
    s.wb_rd = 5'd9; s.wb_reg_write = 1'b1;
    applyStimulus("fwd_mix", s, CTL_RUN, FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00, 1'b0);
    s = idle; s.ex_rs = 5'd6; s.ex_rt = 5'd6; s.mem_rd = 5'd6;
    s.wb_rd = 5'd6; s.wb_reg_write = 1'b1;
    applyStimulus("fwd_nowr", s, CTL_RUN, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00, 1'b0);
    s = idle; s.mem_reg_write = 1'b1; s.wb_reg_write = 1'b1;
    s.ex_reg_write = 1'b1; s.ex_mem_read = 1'b1; s.id_uses_rs = 1'b1; s.id_uses_rt = 1'b1;
    applyStimulus("zero_reg", s, CTL_RUN, 2'b00, 2'b00, 1'b0);

    s = idle; s.ex_rd = 5'd7; s.ex_reg_write = 1'b1; s.ex_mem_read = 1'b1;
    s.id_rt = 5'd7; s.id_uses_rt = 1'b1;
    applyStimulus("lu_rt", s, CTL_STALL, 2'b00, 2'b00, 1'b0);
    s = lu; s.ex_branch_taken = 1'b1;
    applyStimulus("br_lu", s, CTL_BR, 2'b00, 2'b00, 1'b0);
    s = idle; s.id_is_md = 1'b1; s.ex_branch_taken = 1'b1;
    applyStimulus("br_md", s, CTL_BR, 2'b00, 2'b00, 1'b0);
    applyStimulus("no_issue", idle, CTL_RUN, 2'b00, 2'b00, 1'b0);

    s = idle; s.id_is_md = 1'b1;
    applyStimulus("mult", s, CTL_RUN, 2'b00, 2'b00, 1'b0);
    s = idle; s.id_reads_hilo = 1'b1;
    for (int i = 0; i < LAT; i++) applyStimulus("mfhi_hold", s, CTL_STALL, 2'b00, 2'b00, 1'b1);
    applyStimulus("mfhi_go", s, CTL_RUN, 2'b00, 2'b00, 1'b0);

    s = idle; s.id_is_md = 1'b1;
    applyStimulus("mult2", s, CTL_RUN, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < LAT; i++) applyStimulus("md_hold", s, CTL_STALL, 2'b00, 2'b00, 1'b1);
    applyStimulus("md_go", s, CTL_RUN, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("md_wait", idle, CTL_RUN, 2'b00, 2'b00, 1'b1);
    s = idle; s.rst = 1'b1;
    applyStimulus("md_rst", s, CTL_RST, 2'b00, 2'b00, 1'b1);
    applyStimulus("md_abort", idle, CTL_RUN, 2'b00, 2'b00, 1'b0);

    for (int i = 0; i < (1 << CW) + 3; i++) applyStimulus("sat", lu, CTL_STALL, 2'b00, 2'b00, 1'b0);
    applyStimulus("sat_hold", idle, CTL_RUN, 2'b00, 2'b00, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
